// File: rtl/sample_sequencer.sv
// sample_sequencer: per-sample responder behind the training Control block.
// Walks the sample memory for a train pass (forward + update per sample) or a
// validation pass (forward only, accumulating the returned error), then
// strobes S_Train / S_Error back to Control.
// Optional build macro: SAMPLE_SEQ_ERR_SAT_EN
//   defined   -> Error accumulator saturates at all-ones
//   undefined -> Error accumulator wraps modulo 2^BITS
module sample_sequencer #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            TR,
  input  logic            VL,
  input  logic            END,
  input  logic [BITS-1:0] TRAIN,
  input  logic [BITS-1:0] VALID,
  output logic [BITS-1:0] addr,
  output logic            fwd_req,
  input  logic            fwd_ack,
  input  logic [BITS-1:0] fwd_err,
  output logic            upd_req,
  input  logic            upd_ack,
  output logic            S_Train,
  output logic            S_Error,
  output logic [BITS-1:0] Error,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_FWD  = 3'd1,
    T_UPD  = 3'd2,
    T_DONE = 3'd3,
    V_FWD  = 3'd4,
    V_DONE = 3'd5
  } state_t;

  state_t          state;
  logic [BITS-1:0] idx;
  logic [BITS-1:0] err_next;
  logic            last_train;
  logic            last_valid;

  // Current sample is the final one of its pass
  assign last_train = (idx == BITS'(TRAIN - BITS'(1)));
  assign last_valid = (idx == BITS'(VALID - BITS'(1)));

`ifdef SAMPLE_SEQ_ERR_SAT_EN
  logic [BITS:0] err_sum;

  // Accumulate with a carry bit and clamp to all-ones on overflow
  assign err_sum  = {1'b0, Error} + {1'b0, fwd_err};
  assign err_next = err_sum[BITS] ? {BITS{1'b1}} : err_sum[BITS-1:0];
`else
  // Accumulate modulo 2^BITS
  assign err_next = Error + fwd_err;
`endif

  // Sequencer FSM with registered handshakes, strobes, address and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      addr    <= '0;
      Error   <= '0;
      fwd_req <= 1'b0;
      upd_req <= 1'b0;
      S_Train <= 1'b0;
      S_Error <= 1'b0;
      busy    <= 1'b0;
    end else if (END) begin
      // Abort: back to IDLE, drop requests, keep Error, no strobe
      state   <= IDLE;
      fwd_req <= 1'b0;
      upd_req <= 1'b0;
      S_Train <= 1'b0;
      S_Error <= 1'b0;
      busy    <= 1'b0;
    end else begin
      S_Train <= 1'b0;
      S_Error <= 1'b0;
      case (state)
        IDLE: begin
          if (TR) begin
            idx  <= '0;
            addr <= '0;
            busy <= 1'b1;
            if (TRAIN == '0) begin
              state   <= T_DONE;
              S_Train <= 1'b1;
            end else begin
              state <= T_FWD;
            end
          end else if (VL) begin
            idx   <= '0;
            addr  <= TRAIN;
            Error <= '0;
            busy  <= 1'b1;
            if (VALID == '0) begin
              state   <= V_DONE;
              S_Error <= 1'b1;
            end else begin
              state <= V_FWD;
            end
          end
        end

        T_FWD: begin
          // Request goes up one cycle after entry; error is not used in training
          if (!fwd_req) begin
            fwd_req <= 1'b1;
          end else if (fwd_ack) begin
            fwd_req <= 1'b0;
            state   <= T_UPD;
          end
        end

        T_UPD: begin
          if (!upd_req) begin
            upd_req <= 1'b1;
          end else if (upd_ack) begin
            upd_req <= 1'b0;
            if (last_train) begin
              state   <= T_DONE;
              S_Train <= 1'b1;
            end else begin
              idx   <= idx + BITS'(1);
              addr  <= addr + BITS'(1);
              state <= T_FWD;
            end
          end
        end

        V_FWD: begin
          if (!fwd_req) begin
            fwd_req <= 1'b1;
          end else if (fwd_ack) begin
            fwd_req <= 1'b0;
            Error   <= err_next;
            if (last_valid) begin
              state   <= V_DONE;
              S_Error <= 1'b1;
            end else begin
              idx  <= idx + BITS'(1);
              addr <= addr + BITS'(1);
            end
          end
        end

        T_DONE, V_DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          fwd_req <= 1'b0;
          upd_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer: randomized-latency datapath
// responder plus a pass-level reference model of addresses and Error.
module tb_sample_sequencer;

  localparam int unsigned BITS = 16;
  localparam longint MAXV = (longint'(1) << BITS) - 1;
`ifdef SAMPLE_SEQ_ERR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [BITS-1:0] word_q_t[$];

  logic            clk = 1'b0;
  logic            rst;
  logic            TR, VL, END;
  logic [BITS-1:0] TRAIN, VALID;
  logic [BITS-1:0] addr;
  logic            fwd_req, upd_req;
  logic            fwd_ack = 1'b0;
  logic            upd_ack = 1'b0;
  logic [BITS-1:0] fwd_err = '0;
  logic            S_Train, S_Error, busy;
  logic [BITS-1:0] Error;

  int n_checks = 0;
  int n_pass   = 0;

  // responder / monitor state
  int      fwd_cnt = 0, upd_cnt = 0, fwd_lat = 0, upd_lat = 0;
  int      acks_given = 0;
  int      ack_limit  = 32'h3fff_ffff;
  bit      force_ack  = 1'b0;
  int      overlap = 0, s_train_cnt = 0, s_error_cnt = 0;
  word_q_t err_src, fwd_addrs, upd_addrs;

  sample_sequencer #(.BITS(BITS)) dut (
    .clk(clk), .rst(rst), .TR(TR), .VL(VL), .END(END),
    .TRAIN(TRAIN), .VALID(VALID), .addr(addr),
    .fwd_req(fwd_req), .fwd_ack(fwd_ack), .fwd_err(fwd_err),
    .upd_req(upd_req), .upd_ack(upd_ack),
    .S_Train(S_Train), .S_Error(S_Error), .Error(Error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath responder and event monitor, acting on the falling edge
  always @(negedge clk) begin
    fwd_ack = 1'b0;
    upd_ack = 1'b0;
    if (!rst && fwd_req) begin
      if (fwd_cnt == 0) begin
        fwd_addrs.push_back(addr);
        fwd_lat = $urandom_range(0, 3);
      end
      if (fwd_cnt == fwd_lat && acks_given < ack_limit) begin
        fwd_ack = 1'b1;
        acks_given++;
        if (err_src.size() > 0) fwd_err = err_src.pop_front();
        else fwd_err = BITS'($urandom);
      end
      fwd_cnt++;
    end else begin
      fwd_cnt = 0;
    end
    if (!rst && upd_req) begin
      if (upd_cnt == 0) begin
        upd_addrs.push_back(addr);
        upd_lat = $urandom_range(0, 3);
      end
      if (upd_cnt == upd_lat) upd_ack = 1'b1;
      upd_cnt++;
    end else begin
      upd_cnt = 0;
    end
    if (force_ack) begin
      fwd_ack = 1'b1;
      upd_ack = 1'b1;
      fwd_err = 16'h1234;
    end
    if (fwd_req && upd_req) overlap++;
    if (S_Train) s_train_cnt++;
    if (S_Error) s_error_cnt++;
  end

  function automatic string q2s(input word_q_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return {"[", s, "]"};
  endfunction

  function automatic bit q_differs(input word_q_t a, input word_q_t b);
    if (a.size() != b.size()) return 1'b1;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: accumulated validation error for a list of per-sample errors
  function automatic logic [BITS-1:0] model_error(input word_q_t errs);
    longint acc = 0;
    foreach (errs[i]) begin
      acc += longint'(errs[i]);
      if (SAT) begin
        if (acc > MAXV) acc = MAXV;
      end else begin
        acc = acc % (MAXV + 1);
      end
    end
    return BITS'(acc);
  endfunction

  task automatic clear_logs();
    fwd_addrs.delete();
    upd_addrs.delete();
    err_src.delete();
  endtask

  task automatic wait_strobe(input bit err_strobe, input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if ((err_strobe ? S_Error : S_Train) === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; TR = 1'b0; VL = 1'b0; END = 1'b0; TRAIN = '0; VALID = '0;
    #3;
    n_checks++; if (addr !== '0) $display("FAIL reset_addr: got %h want 0", addr); else n_pass++;
    n_checks++; if ({fwd_req, upd_req} !== 2'b00) $display("FAIL reset_req: got %b want 00", {fwd_req, upd_req}); else n_pass++;
    n_checks++; if ({S_Train, S_Error, busy} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {S_Train, S_Error, busy}); else n_pass++;
    n_checks++; if (Error !== '0) $display("FAIL reset_error: got %h want 0", Error); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_train(input int n);
    word_q_t exp;
    bit seen;
    int st0, se0;
    @(posedge clk); #1;
    clear_logs();
    st0 = s_train_cnt; se0 = s_error_cnt;
    TRAIN = BITS'(n); TR = 1'b1;
    @(posedge clk); #1 TR = 1'b0;
    wait_strobe(1'b0, 20 * n + 20, seen);
    n_checks++; if (!seen) $display("FAIL train_strobe n=%0d: got no S_Train want pulse", n); else n_pass++;
    @(negedge clk);
    n_checks++; if ({S_Train, busy} !== 2'b00) $display("FAIL train_after n=%0d: got S_Train,busy=%b want 00", n, {S_Train, busy}); else n_pass++;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) exp.push_back(BITS'(i));
    n_checks++; if (q_differs(fwd_addrs, exp)) $display("FAIL train_fwd_addr: got %s want %s", q2s(fwd_addrs), q2s(exp)); else n_pass++;
    n_checks++; if (q_differs(upd_addrs, exp)) $display("FAIL train_upd_addr: got %s want %s", q2s(upd_addrs), q2s(exp)); else n_pass++;
    n_checks++; if (s_train_cnt - st0 != 1 || s_error_cnt != se0) $display("FAIL train_pulses: got S_Train=%0d S_Error=%0d want 1 0", s_train_cnt - st0, s_error_cnt - se0); else n_pass++;
  endtask

  task automatic test_valid(input logic [BITS-1:0] train, input word_q_t errs);
    word_q_t exp;
    logic [BITS-1:0] exp_err;
    bit seen;
    int n, se0;
    n = errs.size();
    exp_err = model_error(errs);
    for (int i = 0; i < n; i++) exp.push_back(BITS'(longint'(train) + i));
    @(posedge clk); #1;
    clear_logs();
    foreach (errs[i]) err_src.push_back(errs[i]);
    se0 = s_error_cnt;
    TRAIN = train; VALID = BITS'(n); VL = 1'b1;
    @(posedge clk); #1 VL = 1'b0;
    wait_strobe(1'b1, 20 * n + 20, seen);
    n_checks++; if (!seen) $display("FAIL valid_strobe n=%0d: got no S_Error want pulse", n); else n_pass++;
    n_checks++; if (Error !== exp_err) $display("FAIL valid_error: got %h want %h", Error, exp_err); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++; if (Error !== exp_err || busy !== 1'b0) $display("FAIL valid_hold: got Error=%h busy=%b want %h 0", Error, busy, exp_err); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (q_differs(fwd_addrs, exp)) $display("FAIL valid_addr: got %s want %s", q2s(fwd_addrs), q2s(exp)); else n_pass++;
    n_checks++; if (upd_addrs.size() != 0 || s_error_cnt - se0 != 1) $display("FAIL valid_misc: got upd=%0d S_Error=%0d want 0 1", upd_addrs.size(), s_error_cnt - se0); else n_pass++;
  endtask

  task automatic test_tr_vl_same_cycle();
    word_q_t exp;
    bit seen;
    int se0;
    exp.push_back(16'd0); exp.push_back(16'd1);
    @(posedge clk); #1;
    clear_logs();
    se0 = s_error_cnt;
    TRAIN = 16'd2; VALID = 16'd3; TR = 1'b1; VL = 1'b1;
    @(posedge clk); #1 begin TR = 1'b0; VL = 1'b0; end
    wait_strobe(1'b0, 80, seen);
    n_checks++; if (!seen) $display("FAIL both_strobe: got no S_Train want pulse"); else n_pass++;
    repeat (5) @(posedge clk); #1;
    n_checks++; if (q_differs(fwd_addrs, exp)) $display("FAIL both_addr: got %s want %s", q2s(fwd_addrs), q2s(exp)); else n_pass++;
    n_checks++; if (s_error_cnt != se0) $display("FAIL both_no_serror: got %0d pulses want 0", s_error_cnt - se0); else n_pass++;
  endtask

  task automatic test_zero_counts();
    bit seen;
    @(posedge clk); #1;
    clear_logs();
    TRAIN = '0; TR = 1'b1;
    @(posedge clk); #1 TR = 1'b0;
    wait_strobe(1'b0, 5, seen);
    n_checks++; if (!seen) $display("FAIL zero_train_strobe: got no S_Train want pulse"); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (fwd_addrs.size() + upd_addrs.size() != 0) $display("FAIL zero_train_req: got %0d requests want 0", fwd_addrs.size() + upd_addrs.size()); else n_pass++;
    VALID = '0; VL = 1'b1;
    @(posedge clk); #1 VL = 1'b0;
    wait_strobe(1'b1, 5, seen);
    n_checks++; if (!seen) $display("FAIL zero_valid_strobe: got no S_Error want pulse"); else n_pass++;
    n_checks++; if (Error !== '0) $display("FAIL zero_valid_error: got %h want 0", Error); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (fwd_addrs.size() != 0) $display("FAIL zero_valid_req: got %0d requests want 0", fwd_addrs.size()); else n_pass++;
  endtask

  task automatic test_end_abort();
    int se0;
    bit ok;
    @(posedge clk); #1;
    clear_logs();
    err_src.push_back(16'd3); err_src.push_back(16'd4);
    se0 = s_error_cnt;
    ack_limit = acks_given + 1;
    TRAIN = 16'd20; VALID = 16'd4; VL = 1'b1;
    @(posedge clk); #1 VL = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (fwd_addrs.size() == 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (!ok) $display("FAIL end_setup: got %0d requests want 2", fwd_addrs.size()); else n_pass++;
    END = 1'b1;
    @(posedge clk); #1 END = 1'b0;
    @(negedge clk);
    n_checks++; if ({fwd_req, busy} !== 2'b00) $display("FAIL end_abort: got fwd_req,busy=%b want 00", {fwd_req, busy}); else n_pass++;
    @(posedge clk); #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({fwd_req, upd_req, busy} !== 3'b000) $display("FAIL end_late_ack: got %b want 000", {fwd_req, upd_req, busy}); else n_pass++;
    n_checks++; if (Error !== 16'd3) $display("FAIL end_error_kept: got %h want 0003", Error); else n_pass++;
    n_checks++; if (s_error_cnt != se0) $display("FAIL end_no_serror: got %0d pulses want 0", s_error_cnt - se0); else n_pass++;
    ack_limit = 32'h3fff_ffff;
    @(posedge clk); #1 clear_logs();
  endtask

  task automatic test_mid_reset();
    bit ok;
    @(posedge clk); #1;
    clear_logs();
    TRAIN = 16'd5; TR = 1'b1;
    @(posedge clk); #1 TR = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (fwd_addrs.size() >= 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (!ok) $display("FAIL rst_setup: got %0d requests want 2", fwd_addrs.size()); else n_pass++;
    @(negedge clk); #2 rst = 1'b1;
    #1;
    n_checks++; if ({fwd_req, upd_req, S_Train, S_Error, busy} !== 5'b0) $display("FAIL rst_async_flags: got %b want 00000", {fwd_req, upd_req, S_Train, S_Error, busy}); else n_pass++;
    n_checks++; if (addr !== '0 || Error !== '0) $display("FAIL rst_async_data: got addr=%h Error=%h want 0 0", addr, Error); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 clear_logs();
  endtask

  initial begin
    word_q_t errs;
    test_reset();
    test_train(3);
    errs = {16'd5, 16'd7, 16'd1, 16'd2};
    test_valid(16'd10, errs);
    test_tr_vl_same_cycle();
    test_zero_counts();
    errs = {16'hFFF0, 16'h0020};
    test_valid(16'd7, errs);
    for (int it = 0; it < 4; it++) begin
      test_train($urandom_range(1, 6));
      errs.delete();
      for (int k = 0, n = $urandom_range(1, 6); k < n; k++) errs.push_back(BITS'($urandom));
      test_valid((it == 0) ? 16'hFFFE : BITS'($urandom), errs);
    end
    test_end_abort();
    test_mid_reset();
    test_train(2);
    n_checks++; if (overlap != 0) $display("FAIL req_overlap: got %0d cycles want 0", overlap); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
